spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI slave endpoint that pairs with the team's SPI_BASE-style masters; used for loopback test of
//  masters and as a config port when the FPGA itself is the SPI target. Oversamples SCLK/CS_N/MOSI
//  on the system clock, deserialises MSB-first words, and drives MISO from a parallel tx word.
//  Supports all four CPOL/CPHA modes and back-to-back words within one CS_N frame.
// PARAMETERS
//  DATAWIDTH    32  bits per word (1..255)
//  SYNC_STAGES  2   flip-flop synchroniser depth on sclk/cs_n/mosi (>=2)
// PORTS
//  clk       in   1          system clock; sclk frequency must be <= clk/8
//  rst       in   1          synchronous reset, active-low
//  CPOL      in   1          SCLK idle level; latched at frame start
//  CPHA      in   1          0: sample on leading edge, 1: sample on trailing edge; latched at frame start
//  sclk      in   1          SPI clock from master (asynchronous)
//  cs_n      in   1          chip select, active-low (asynchronous)
//  mosi      in   1          serial data in (asynchronous)
//  miso      out  1          serial data out; 0 when not selected
//  tx_data   in   DATAWIDTH  word to shift out on MISO
//  tx_load   out  1          1-cycle pulse: tx_data captured this cycle
//  rx_data   out  DATAWIDTH  last complete received word; held until next word completes
//  rx_valid  out  1          1-cycle pulse: rx_data updated
//  rx_abort  out  1          1-cycle pulse: frame ended with a partial word (bits discarded)
//  busy      out  1          1 while in ACTIVE state
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): miso=0, tx_load=0, rx_data=0, rx_valid=0, rx_abort=0, busy=0,
//    bit counter=0, shift regs=0, synchronisers preset to idle (cs_n=1, sclk=0), state=ARM.
//  - Inputs pass SYNC_STAGES FFs, then one edge-detect register: an external edge is seen
//    SYNC_STAGES+1 clk cycles later. All logic below uses the synchronised versions.
//  - Sample edge = rising when CPOL==CPHA, else falling; shift edge = opposite edge.
//  - FSM: ARM -> IDLE when cs_n seen high (guards against reset mid-frame: a frame already in
//    progress at reset release is ignored until cs_n deasserts).
//    IDLE -> ACTIVE on cs_n falling: latch CPOL/CPHA, capture tx_data into tx shift reg, pulse
//    tx_load, bit counter=0, miso=tx MSB immediately (valid for CPHA=0 first leading edge).
//    ACTIVE -> IDLE on cs_n rising.
//  - ACTIVE, sample edge: rx_shift <= {rx_shift[DATAWIDTH-2:0], mosi}; counter+1. When counter
//    reaches DATAWIDTH: rx_data <= completed word, rx_valid pulses the next cycle, counter wraps to 0.
//  - ACTIVE, shift edge: CPHA=0: ignore the shift edge that precedes the first sample of a frame
//    (none exists) and shift tx reg left, miso=next bit; CPHA=1: the first shift edge of each word
//    drives bit DATAWIDTH-1, subsequent ones shift. At word boundary (counter wrapped) the next
//    shift edge reloads tx shift reg from tx_data and pulses tx_load; CPHA=0 reloads on the
//    wrap cycle itself so MSB is valid before the next leading edge.
//  - cs_n rising with counter!=0: rx_abort pulses 1 cycle, partial bits dropped, rx_data unchanged.
//  - cs_n rising detected in same cycle as the final sample edge: word completes (rx_valid),
//    no rx_abort.
//  - SCLK edges while IDLE/ARM ignored; miso=0 outside ACTIVE.
//  - CPOL/CPHA changes while ACTIVE have no effect until next frame.
//  - rx_valid and rx_abort never asserted in the same cycle.
// TESTING
//  1 Mode 0, master CLKDIV=4, send 0xA5C3_0F96, tx_data=0x1234_5678 -> one rx_valid, rx_data=0xA5C3_0F96,
//    master sees 0x1234_5678 on MISO, one tx_load at CS fall.
//  2 Modes 1,2,3 each with 0x8000_0001 and 0x7FFF_FFFE -> rx_data exact match, MISO word exact.
//  3 One CS frame, 3 words 0x11111111/0x22222222/0x33333333, tx_data updated after each tx_load ->
//    3 rx_valid in order, 3 tx_load, no rx_abort.
//  4 Deassert cs_n after 17 bits -> rx_abort pulse once, rx_data keeps previous word, no rx_valid.
//  5 Assert rst mid-frame at bit 10, release, master continues -> no rx_valid/rx_abort for that
//    frame; next full frame 0xDEADBEEF received correctly.
//  6 cs_n high, toggle sclk/mosi randomly for 200 cycles -> all outputs stay 0, busy=0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   SPI slave endpoint. SCLK, CS_N and MOSI are oversampled on clk through a
//   SYNC_STAGES flop synchroniser plus one edge-detect register. Words are
//   received MSB first. A parallel tx word is shifted out MSB first on MISO.
//   All four CPOL/CPHA modes are supported, as are back-to-back words within
//   one CS_N frame.
//
// Ports
//   clk       system clock (sclk must be <= clk/8)
//   rst       synchronous reset, active low
//   CPOL      SCLK idle level, latched at frame start
//   CPHA      0: sample on leading edge, 1: sample on trailing edge
//   sclk      SPI clock from master (async)
//   cs_n      chip select, active low (async)
//   mosi      serial data in (async)
//   miso      serial data out, 0 when not selected
//   tx_data   word to shift out on MISO
//   tx_load   1-cycle pulse: tx_data captured this cycle
//   rx_data   last complete received word
//   rx_valid  1-cycle pulse: rx_data updated
//   rx_abort  1-cycle pulse: frame ended with a partial word
//   busy      1 while a frame is active
module spi_slave_rx #(
    parameter int DATAWIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CPOL,
    input  logic                 CPHA,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [DATAWIDTH-1:0] tx_data,
    output logic                 tx_load,
    output logic [DATAWIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_abort,
    output logic                 busy
);

    localparam int CW = (DATAWIDTH < 2) ? 1 : $clog2(DATAWIDTH);

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic [SYNC_STAGES:0]   flush_pipe;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   start, stop;
    logic                   samp_rise_q, cpha_q;
    logic                   samp_edge, shft_edge, word_done;
    logic [CW-1:0]          bit_cnt, cnt_next;
    logic [DATAWIDTH-1:0]   rx_shift, rx_next, tx_shift;
    logic                   hold_shift, reload_pend;

    // Synchronisers preset to the idle bus (cs_n high, sclk low). flush_pipe
    // marks when every stage holds a real sample, so ARM never trusts the
    // preset value of cs_n.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sclk_d     <= 1'b0;
            cs_d       <= 1'b1;
            flush_pipe <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            cs_d       <= cs_sync[SYNC_STAGES-1];
            flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ARM;
        else      state <= state_nxt;
    end

    // FSM next state; ARM waits for a clean cs_n high so a frame already in
    // flight at reset release is ignored.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        case (state)
            ARM:     if (flush_pipe[SYNC_STAGES] && cs_s) state_nxt = IDLE;
            IDLE:    if (cs_fall) begin
                         state_nxt = ACTIVE;
                         start     = 1'b1;
                     end
            ACTIVE:  if (cs_rise) begin
                         state_nxt = IDLE;
                         stop      = 1'b1;
                     end
            default: state_nxt = ARM;
        endcase
    end

    // Sample edge is rising when CPOL==CPHA, shift edge is the other one.
    always_comb begin
        samp_edge = (state == ACTIVE) && (samp_rise_q ? sclk_rise : sclk_fall);
        shft_edge = (state == ACTIVE) && (samp_rise_q ? sclk_fall : sclk_rise);
        rx_next   = (rx_shift << 1) | DATAWIDTH'(mosi_s);
        word_done = samp_edge && (bit_cnt == CW'(DATAWIDTH - 1));
        cnt_next  = bit_cnt;
        if (word_done)      cnt_next = '0;
        else if (samp_edge) cnt_next = bit_cnt + CW'(1);
    end

    // Datapath.
    // hold_shift: the next shift edge leaves tx_shift alone. Used for the
    //   first CPHA=1 leading edge (MSB already on MISO) and for the CPHA=0
    //   trailing edge after a word's last sample (word already reloaded).
    // reload_pend: CPHA=1 only; the first shift edge of the next word loads
    //   tx_data, so a frame's last word does not trigger a reload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_load     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_abort    <= 1'b0;
            rx_data     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            samp_rise_q <= 1'b0;
            cpha_q      <= 1'b0;
            hold_shift  <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            rx_abort <= 1'b0;
            if (start) begin
                samp_rise_q <= (CPOL == CPHA);
                cpha_q      <= CPHA;
                tx_shift    <= tx_data;
                tx_load     <= 1'b1;
                bit_cnt     <= '0;
                rx_shift    <= '0;
                hold_shift  <= CPHA;
                reload_pend <= 1'b0;
            end else if (state == ACTIVE) begin
                if (samp_edge) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= cnt_next;
                    if (word_done) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        if (!cpha_q) begin
                            // MSB must be on MISO before the next leading edge
                            tx_shift   <= tx_data;
                            tx_load    <= 1'b1;
                            hold_shift <= 1'b1;
                        end else begin
                            reload_pend <= 1'b1;
                        end
                    end
                end
                if (shft_edge) begin
                    if (reload_pend) begin
                        tx_shift    <= tx_data;
                        tx_load     <= 1'b1;
                        reload_pend <= 1'b0;
                    end else if (hold_shift) begin
                        hold_shift <= 1'b0;
                    end else begin
                        tx_shift <= tx_shift << 1;
                    end
                end
                if (stop) begin
                    // a final sample in this same cycle has already wrapped cnt_next
                    rx_abort <= (cnt_next != '0);
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                end
            end
        end
    end

    assign miso = (state == ACTIVE) ? tx_shift[DATAWIDTH-1] : 1'b0;
    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a behavioural SPI master (half period of
// HP clk cycles) drives frames in all four modes; pulse counters and a log of
// received words are kept by a negedge monitor.
module tb_spi_slave_rx;

    localparam int HP = 4;

    logic        clk = 1'b0;
    logic        rst, CPOL, CPHA, sclk, cs_n, mosi, miso;
    logic [31:0] tx_data, rx_data;
    logic        tx_load, rx_valid, rx_abort, busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_valid = 0, n_abort = 0, n_load = 0;
    logic        both_seen = 1'b0;
    logic [31:0] rx_log [64];

    spi_slave_rx #(.DATAWIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .CPOL(CPOL), .CPHA(CPHA), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_abort(rx_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_load)  n_load  <= n_load + 1;
        if (rx_abort) n_abort <= n_abort + 1;
        if (rx_valid) begin
            rx_log[n_valid % 64] <= rx_data;
            n_valid <= n_valid + 1;
        end
        if (rx_valid && rx_abort) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        CPOL = pol;
        CPHA = pha;
        sclk = pol;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Shift nbits of mo starting at bit hi; mi collects MISO at master sample points.
    task automatic xfer(input logic [31:0] mo, input int hi, input int nbits,
                        output logic [31:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = hi - k;
            if (!CPHA) begin
                mosi = mo[i];
                repeat (HP) @(negedge clk);
                mi[i] = miso;
                sclk = ~CPOL;
                repeat (HP) @(negedge clk);
                sclk = CPOL;
            end else begin
                sclk = ~CPOL;
                mosi = mo[i];
                repeat (HP) @(negedge clk);
                mi[i] = miso;
                sclk = CPOL;
                repeat (HP) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [31:0] mi, acc, rx_or;
        logic [31:0] w2 [2];
        logic [31:0] w3 [3];
        logic [31:0] t3 [3];
        int v0, a0, l0;

        rst = 1'b0; CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0; cs_n = 1'b1;
        mosi = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {27'd0, miso, tx_load, rx_valid, rx_abort, busy}, 32'd0);
        check("reset_rx_data", rx_data, 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // 1: mode 0 single word
        tx_data = 32'h1234_5678;
        v0 = n_valid; a0 = n_abort; l0 = n_load;
        frame_begin();
        check("t1_load_at_cs", n_load - l0, 1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        xfer(32'hA5C3_0F96, 31, 32, mi);
        frame_end();
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_rx_data", rx_data, 32'hA5C3_0F96);
        check("t1_miso_word", mi, 32'h1234_5678);
        check("t1_abort_cnt", n_abort - a0, 0);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // 2: modes 1..3, two words each in separate frames
        w2[0] = 32'h8000_0001;
        w2[1] = 32'h7FFF_FFFE;
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            for (int j = 0; j < 2; j++) begin
                tx_data = w2[1-j];
                frame_begin();
                xfer(w2[j], 31, 32, mi);
                frame_end();
                check($sformatf("t2_m%0d_w%0d_rx", m, j), rx_data, w2[j]);
                check($sformatf("t2_m%0d_w%0d_miso", m, j), mi, w2[1-j]);
            end
        end

        // 3: mode 1, three words in one frame, tx_data advanced between words
        set_mode(1'b0, 1'b1);
        w3[0] = 32'h1111_1111; w3[1] = 32'h2222_2222; w3[2] = 32'h3333_3333;
        t3[0] = 32'hAAAA_0001; t3[1] = 32'hBBBB_0002; t3[2] = 32'hCCCC_0003;
        v0 = n_valid; a0 = n_abort; l0 = n_load;
        tx_data = t3[0];
        frame_begin();
        for (int j = 0; j < 3; j++) begin
            xfer(w3[j], 31, 32, mi);
            check($sformatf("t3_miso_w%0d", j), mi, t3[j]);
            if (j < 2) tx_data = t3[j+1];
        end
        frame_end();
        check("t3_valid_cnt", n_valid - v0, 3);
        check("t3_load_cnt", n_load - l0, 3);
        check("t3_abort_cnt", n_abort - a0, 0);
        for (int j = 0; j < 3; j++)
            check($sformatf("t3_rx_w%0d", j), rx_log[(v0 + j) % 64], w3[j]);

        // 4: mode 0, frame cut after 17 bits
        set_mode(1'b0, 1'b0);
        v0 = n_valid; a0 = n_abort;
        frame_begin();
        xfer(32'h5A5A_5A5A, 31, 17, mi);
        frame_end();
        check("t4_abort_cnt", n_abort - a0, 1);
        check("t4_valid_cnt", n_valid - v0, 0);
        check("t4_rx_hold", rx_data, 32'h3333_3333);

        // 5: reset at bit 10, master finishes the word, then a clean frame
        v0 = n_valid; a0 = n_abort;
        frame_begin();
        xfer(32'hCAFE_F00D, 31, 10, mi);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        xfer(32'hCAFE_F00D, 21, 22, mi);
        frame_end();
        check("t5_valid_cnt", n_valid - v0, 0);
        check("t5_abort_cnt", n_abort - a0, 0);
        check("t5_rx_cleared", rx_data, 32'd0);
        tx_data = 32'h0F0F_A5A5;
        frame_begin();
        xfer(32'hDEAD_BEEF, 31, 32, mi);
        frame_end();
        check("t5_valid_after", n_valid - v0, 1);
        check("t5_rx_data", rx_data, 32'hDEAD_BEEF);
        check("t5_miso_word", mi, 32'h0F0F_A5A5);

        // 6: reset, then sclk/mosi noise with cs_n high
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        v0 = n_valid; a0 = n_abort; l0 = n_load;
        acc = '0; rx_or = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            sclk = 1'($urandom);
            mosi = 1'($urandom);
            acc   = acc | {27'd0, miso, tx_load, rx_valid, rx_abort, busy};
            rx_or = rx_or | rx_data;
        end
        check("t6_ctrl_quiet", acc, 32'd0);
        check("t6_rx_quiet", rx_or, 32'd0);
        check("t6_pulse_cnt", (n_valid - v0) + (n_abort - a0) + (n_load - l0), 0);

        check("valid_abort_overlap", {31'd0, both_seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
